// File: rtl/clock_input_conditioner.sv
// Front-panel input conditioner: 2-flop sync + debounce for push/select/hlt and a fixed-width
// step pulse per press. Optional auto-repeat of the step pulse when AUTOREPEAT_EN is defined.
module clock_input_conditioner #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned REPEAT_DELAY    = 25000,
  parameter int unsigned REPEAT_PERIOD   = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic push_raw,
  input  logic select_raw,
  input  logic hlt_raw,
  output logic push_db,
  output logic select_db,
  output logic hlt_db,
  output logic push_pulse
);

  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (PULSE_CYCLES < 1 || 64'(PULSE_CYCLES) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_pulse
    $error("PULSE_CYCLES out of range");
  end
`ifndef AUTOREPEAT_EN
  // Repeat timing has no effect in this build.
  if (REPEAT_DELAY == 0 && REPEAT_PERIOD == 0) begin : g_no_repeat
  end
`endif

  localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYCLES - 1);

  // Bit 0 push, bit 1 select, bit 2 hlt.
  logic [2:0]       raw, sync1_q, sync2_q, db_q;
  logic [CNT_W-1:0] db_cnt_q [3];

  assign raw = {hlt_raw, select_raw, push_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= ~db_q[i];
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] != '1) begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign push_db   = db_q[0];
  assign select_db = db_q[1];
  assign hlt_db    = db_q[2];

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StWaitRel
`ifdef AUTOREPEAT_EN
    , StRepeat
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic             push_prev_q;
  logic             push_rise, blocked;

  assign push_rise = push_db & ~push_prev_q;
  assign blocked   = hlt_db | select_db;

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] PulseLen   = CNT_W'(PULSE_CYCLES);

  // rep_cnt counts clocks since the most recent pulse start.
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_stop_q, rep_stop_d;
  logic             rep_busy;

  assign rep_busy = rep_cnt_q < PulseLen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q  <= '0;
      rep_stop_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_stop_q <= rep_stop_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pulse_cnt_q <= '0;
      push_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      push_prev_q <= push_db;
    end
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    push_pulse  = 1'b0;
`ifdef AUTOREPEAT_EN
    rep_cnt_d  = (rep_cnt_q != '1) ? rep_cnt_q + CNT_W'(1) : rep_cnt_q;
    rep_stop_d = rep_stop_q;
`endif
    case (state_q)
      StIdle: begin
        if (push_rise) begin
          if (blocked) begin
            state_d = StWaitRel;
`ifdef AUTOREPEAT_EN
            rep_stop_d = 1'b1;
`endif
          end else begin
            state_d     = StPulse;
            pulse_cnt_d = '0;
`ifdef AUTOREPEAT_EN
            rep_cnt_d  = '0;
            rep_stop_d = 1'b0;
`endif
          end
        end
      end
      StPulse: begin
        push_pulse = 1'b1;
        if (pulse_cnt_q == PulseLast) state_d = StWaitRel;
        else pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
      end
      StWaitRel: begin
        if (!push_db) begin
          state_d = StIdle;
`ifdef AUTOREPEAT_EN
        end else if (blocked) begin
          rep_stop_d = 1'b1;
        end else if (!rep_stop_q && rep_cnt_q == DelayLast) begin
          state_d   = StRepeat;
          rep_cnt_d = '0;
`endif
        end
      end
`ifdef AUTOREPEAT_EN
      StRepeat: begin
        push_pulse = rep_busy;
        if (!rep_busy) begin
          if (!push_db) begin
            state_d = StIdle;
          end else if (blocked) begin
            state_d    = StWaitRel;
            rep_stop_d = 1'b1;
          end else if (rep_cnt_q == PeriodLast) begin
            rep_cnt_d = '0;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_clock_input_conditioner.sv
// Bench for clock_input_conditioner with DEBOUNCE_CYCLES=8, PULSE_CYCLES=3,
// REPEAT_DELAY=20, REPEAT_PERIOD=10.
module tb_clock_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push_raw = 1'b0, select_raw = 1'b0, hlt_raw = 1'b0;
  logic push_db, select_db, hlt_db, push_pulse;

  clock_input_conditioner #(
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(8),
    .PULSE_CYCLES   (3),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push_raw  (push_raw),
    .select_raw(select_raw),
    .hlt_raw   (hlt_raw),
    .push_db   (push_db),
    .select_db (select_db),
    .hlt_db    (hlt_db),
    .push_pulse(push_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic push, sel, hlt;
    int   cycles;
    logic e_push, e_sel, e_hlt;
    int   e_pulses;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];
  int   exp_starts[$];
  int   starts[$];
  int   widths[$];
  int   cyc, run;
  logic prev;
  int   total, bad;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sample #1 after each edge; track pulse start cycles and widths.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (push_pulse) begin
      if (!prev) starts.push_back(cyc);
      run++;
    end else if (run > 0) begin
      widths.push_back(run);
      run = 0;
    end
    prev = push_pulse;
  endtask

  task automatic clear_obs();
    starts.delete();
    widths.delete();
    cyc = 0;
  endtask

  initial begin
    vec_t e;
    int   changes, found;
    logic last_db;
    total = 0; bad = 0; cyc = 0; run = 0; prev = 1'b0;

    vecs[0] = '{push: 0, sel: 0, hlt: 1, cycles: 12, e_push: 0, e_sel: 0, e_hlt: 1, e_pulses: 0};
    vecs[1] = '{push: 1, sel: 0, hlt: 1, cycles: 15, e_push: 1, e_sel: 0, e_hlt: 1, e_pulses: 0};
    vecs[2] = '{push: 0, sel: 0, hlt: 1, cycles: 12, e_push: 0, e_sel: 0, e_hlt: 1, e_pulses: 0};
    vecs[3] = '{push: 0, sel: 0, hlt: 0, cycles: 12, e_push: 0, e_sel: 0, e_hlt: 0, e_pulses: 0};
    vecs[4] = '{push: 1, sel: 0, hlt: 0, cycles: 15, e_push: 1, e_sel: 0, e_hlt: 0, e_pulses: 1};
    vecs[5] = '{push: 0, sel: 0, hlt: 0, cycles: 12, e_push: 0, e_sel: 0, e_hlt: 0, e_pulses: 0};
    vecs[6] = '{push: 0, sel: 1, hlt: 0, cycles: 12, e_push: 0, e_sel: 1, e_hlt: 0, e_pulses: 0};
    vecs[7] = '{push: 1, sel: 1, hlt: 0, cycles: 15, e_push: 1, e_sel: 1, e_hlt: 0, e_pulses: 0};
    vecs[8] = '{push: 0, sel: 0, hlt: 0, cycles: 12, e_push: 0, e_sel: 0, e_hlt: 0, e_pulses: 0};

    // Reset with all raw inputs high.
    push_raw = 1; select_raw = 1; hlt_raw = 1;
    repeat (3) tick();
    check("rst_push_db", push_db, 0);
    check("rst_select_db", select_db, 0);
    check("rst_hlt_db", hlt_db, 0);
    check("rst_pulse", push_pulse, 0);
    rst = 0;
    clear_obs();
    repeat (9) tick();
    check("rel_db_c9", {push_db, select_db, hlt_db}, 3'b000);
    tick();
    check("rel_db_c10", {push_db, select_db, hlt_db}, 3'b111);
    repeat (20) tick();
    check("rel_no_pulse", starts.size(), 0);
    push_raw = 0; select_raw = 0; hlt_raw = 0;
    repeat (12) tick();
    check("idle_db", {push_db, select_db, hlt_db}, 3'b000);

    // Clean press held 30 clocks.
    clear_obs();
    push_raw = 1;
    repeat (9) tick();
    check("press_db_c9", push_db, 0);
    tick();
    check("press_db_c10", push_db, 1);
    repeat (20) tick();
    check("press_pulses", starts.size(), 1);
    if (starts.size() > 0) check("press_start", starts[0], 11);
    check("press_widths", widths.size(), 1);
    if (widths.size() > 0) check("press_width", widths[0], 3);
    push_raw = 0;
    repeat (12) tick();

    // Level table through the scoreboard.
    for (int i = 0; i < 9; i++) begin
      push_raw = vecs[i].push; select_raw = vecs[i].sel; hlt_raw = vecs[i].hlt;
      sb.push_back(vecs[i]);
      clear_obs();
      repeat (vecs[i].cycles) tick();
      e = sb.pop_front();
      check($sformatf("vec%0d_push_db", i), push_db, e.e_push);
      check($sformatf("vec%0d_select_db", i), select_db, e.e_sel);
      check($sformatf("vec%0d_hlt_db", i), hlt_db, e.e_hlt);
      check($sformatf("vec%0d_pulses", i), starts.size(), e.e_pulses);
      foreach (widths[k]) check($sformatf("vec%0d_width", i), widths[k], 3);
    end

    // Bouncy button: toggles every 3 clocks for 40 clocks.
    clear_obs();
    changes = 0;
    last_db = push_db;
    for (int i = 0; i < 52; i++) begin
      if (i < 40 && i % 3 == 0) push_raw = ~push_raw;
      if (i == 40) push_raw = 0;
      tick();
      if (push_db != last_db) changes++;
      last_db = push_db;
    end
    check("bounce_db_changes", changes, 0);
    check("bounce_pulses", starts.size(), 0);

    // Reset on the second clock of a pulse.
    clear_obs();
    push_raw = 1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (push_pulse) found = 1;
    end
    check("rst_mid_found", found, 1);
    tick();
    check("rst_mid_before", push_pulse, 1);
    rst = 1;
    push_raw = 0;
    #1;
    check("rst_mid_drop", push_pulse, 0);
    repeat (3) tick();
    rst = 0;
    clear_obs();
    repeat (30) tick();
    check("rst_mid_after_pulses", starts.size(), 0);
    check("rst_mid_after_db", push_db, 0);

    // Long hold: auto-repeat timing (push_db falls at clock 80).
    clear_obs();
`ifdef AUTOREPEAT_EN
    exp_starts = '{11, 31, 41, 51, 61, 71};
`else
    exp_starts = '{11};
`endif
    push_raw = 1;
    for (int i = 0; i < 100; i++) begin
      if (i == 70) push_raw = 0;
      tick();
    end
    check("hold_pulses", starts.size(), exp_starts.size());
    for (int i = 0; i < 8 && exp_starts.size() > 0 && starts.size() > 0; i++)
      check("hold_start", starts.pop_front(), exp_starts.pop_front());
    foreach (widths[k]) check("hold_width", widths[k], 3);
    check("hold_end_db", push_db, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
